fetch_align_ctrl: RTL

Fetch sequencer between the I-cache and the instruction decode stage. It owns the fetch PC and drives I-cache word addresses. It splits each returned 32-bit word into 16-bit (RVC) and 32-bit instructions, including 32-bit instructions that straddle two words, using a one-halfword carry buffer. It handles decode back-pressure, cache stalls and branch redirects, and presents one aligned instruction per cycle, tagged with its PC, to the decompressor/decoder.

---
 rtl/fetch_align_ctrl_if.sv | 34 +++
 rtl/fetch_align_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fetch_align_ctrl_if.sv
// Fetch-side bundle between fetch_align_ctrl, the I-cache and decode.
//   ic_req/ic_addr                 : word-aligned cache read request (to I-cache)
//   ic_rdata/ic_stall              : returned word and miss indication (from I-cache)
//   id_stall                       : decode back-pressure
//   redirect/redirect_pc           : branch/jump redirect
//   instr_valid/instr/instr_pc/
//   instr_is_c                     : aligned instruction presented to decode
// modport master : the fetch sequencer
// modport slave  : the cache/decode environment
interface fetch_align_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic [31:0]       ic_rdata;
  logic              ic_stall;
  logic              id_stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_is_c;

  modport master (
    output ic_req, ic_addr, instr_valid, instr, instr_pc, instr_is_c,
    input  ic_rdata, ic_stall, id_stall, redirect, redirect_pc
  );

  modport slave (
    input  ic_req, ic_addr, instr_valid, instr, instr_pc, instr_is_c,
    output ic_rdata, ic_stall, id_stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_align_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues word reads to the I-cache and
// splits returned words into 16-bit (RVC) and 32-bit instructions, using a
// one-halfword carry buffer for 32-bit instructions straddling two words.
// One aligned instruction per cycle, tagged with its PC, goes to decode.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : fetch_align_ctrl_if.master (cache request/response, decode
//            stall, redirect, instruction output)
// Configuration macro RVC_EN: when defined, compressed instructions and the
// halfword alignment buffer are built; when undefined every word is a
// 32-bit instruction and instr_is_c is tied to 0.
module fetch_align_ctrl #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_align_ctrl_if.master   bus
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fa;
  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              req;
  logic              adv;
  logic [31:0]       w;

  assign w = bus.ic_rdata;

`ifdef RVC_EN
  typedef enum logic [1:0] {S_ALIGNED, S_BUF, S_MISS} state_t;

  state_t      state_q, state_d;
  logic [15:0] hbuf_q, hbuf_d;
  logic        isc_q, isc_d;
  logic        unused_rpc0;

  assign unused_rpc0 = bus.redirect_pc[0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hbuf_d  = hbuf_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    isc_d   = isc_q;

    // In S_BUF the halfword at pc is already held, so the next word fetched
    // is the one containing pc+2.
    fa  = (state_q == S_BUF) ? pc_q + ADDR_W'(2) : pc_q;
    // A buffered RVC is self-contained and needs no cache access.
    req = rst_n & ((state_q != S_BUF) | (hbuf_q[1:0] == 2'b11));
    adv = ~bus.id_stall & (~req | ~bus.ic_stall);

    if (bus.redirect) begin
      pc_d    = {bus.redirect_pc[ADDR_W-1:1], 1'b0};
      state_d = bus.redirect_pc[1] ? S_MISS : S_ALIGNED;
      hbuf_d  = '0;
      valid_d = 1'b0;
    end else if (adv) begin
      valid_d = 1'b1;
      ipc_d   = pc_q;
      case (state_q)
        S_ALIGNED: begin
          if (w[1:0] == 2'b11) begin
            instr_d = w;
            isc_d   = 1'b0;
            pc_d    = pc_q + ADDR_W'(4);
          end else begin
            instr_d = {16'h0000, w[15:0]};
            isc_d   = 1'b1;
            pc_d    = pc_q + ADDR_W'(2);
            hbuf_d  = w[31:16];
            state_d = S_BUF;
          end
        end
        S_BUF: begin
          if (hbuf_q[1:0] != 2'b11) begin
            instr_d = {16'h0000, hbuf_q};
            isc_d   = 1'b1;
            pc_d    = pc_q + ADDR_W'(2);
            state_d = S_ALIGNED;
          end else begin
            instr_d = {w[15:0], hbuf_q};
            isc_d   = 1'b0;
            pc_d    = pc_q + ADDR_W'(4);
            hbuf_d  = w[31:16];
          end
        end
        S_MISS: begin
          // Only the upper halfword of the word is at pc; buffer it, no emit.
          valid_d = 1'b0;
          ipc_d   = ipc_q;
          hbuf_d  = w[31:16];
          state_d = S_BUF;
        end
        default: state_d = S_ALIGNED;
      endcase
    end else if (~bus.id_stall) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ALIGNED;
      hbuf_q  <= '0;
      isc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hbuf_q  <= hbuf_d;
      isc_q   <= isc_d;
    end
  end

  assign bus.instr_is_c = isc_q;
`else
  logic unused_rpc;

  assign unused_rpc = ^bus.redirect_pc[1:0];

  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;

    fa  = pc_q;
    req = rst_n;
    adv = ~bus.id_stall & ~bus.ic_stall;

    if (bus.redirect) begin
      pc_d    = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      valid_d = 1'b0;
    end else if (adv) begin
      valid_d = 1'b1;
      instr_d = w;
      ipc_d   = pc_q;
      pc_d    = pc_q + ADDR_W'(4);
    end else if (~bus.id_stall) begin
      valid_d = 1'b0;
    end
  end

  assign bus.instr_is_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= RESET_PC;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  assign bus.ic_req      = req;
  assign bus.ic_addr     = {fa[ADDR_W-1:2], 2'b00};
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = ipc_q;

endmodule
